// File: rtl/alu_pipe.sv
// alu_pipe -- handshaked, parametrised ALU with a registered result/flag stage.
//
// Eight operations: ADD, SUB, AND, OR, XOR, SHL, SHR (logical) and MUL.
// All single-cycle ops produce their result one edge after acceptance.
// MUL is an iterative shift-add over WIDTH cycles and blocks new operands
// while it runs.
//
// Build option: define ALU_SAT_EN to make ADD/SUB saturate on signed overflow
// instead of wrapping. The ovf flag still reports the overflow, and carry is
// unaffected. With ALU_SAT_EN undefined, ADD/SUB wrap modulo 2^WIDTH.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset, aborts any MUL
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      block can accept an operand beat
//   a, b       in   WIDTH  operands (shift amount is b[SHW-1:0])
//   op         in   3      opcode: 0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SHL 6 SHR 7 MUL
//   out_valid  out  1      result/flags valid, held until out_ready
//   out_ready  in   1      sink accepts the result
//   result     out  WIDTH  result
//   flags      out  4      {carry, ovf, neg, zero}

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CW  = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t              state_reg, state_next;
  logic                out_valid_reg;
  logic [WIDTH-1:0]    result_reg;
  logic [3:0]          flags_reg;
  logic [2*WIDTH-1:0]  acc_reg;
  logic [2*WIDTH-1:0]  a_sh_reg;
  logic [WIDTH-1:0]    b_sh_reg;
  logic [CW-1:0]       cnt_reg;

  logic                accept;
  logic                pop;
  logic                mul_done;

  logic [WIDTH:0]      sum;
  logic [WIDTH:0]      diff;
  logic [WIDTH-1:0]    alu_res;
  logic                alu_carry;
  logic                alu_ovf;
  logic [3:0]          alu_flags;

  logic [2*WIDTH-1:0]  acc_step;
  logic [3:0]          mul_flags;

  assign accept   = in_valid && in_ready;
  assign pop      = out_valid_reg && out_ready;
  assign mul_done = (state_reg == S_MUL) && (cnt_reg == CNT_LAST);

  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept && op == OP_MUL) state_next = S_MUL;
      S_MUL:   if (mul_done)               state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A new beat may enter only when the output register is empty or is being
  // drained this very cycle; that is also what guarantees a finishing MUL
  // never collides with an unpopped result.
  always_comb begin
    in_ready = !rst && (state_reg == S_IDLE) && (!out_valid_reg || out_ready);
  end

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
        alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];  // borrow out == (a < b) unsigned
        alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL:  alu_res = a << b[SHW-1:0];
      OP_SHR:  alu_res = a >> b[SHW-1:0];
      default: alu_res = '0;  // MUL goes through the iterative path
    endcase
`ifdef ALU_SAT_EN
    // On signed overflow the true result has the sign of a, so clamp towards it.
    if (alu_ovf) begin
      alu_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    alu_flags = {alu_carry, alu_ovf, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // ---------------- shift-add multiply step ----------------
  always_comb begin
    acc_step  = b_sh_reg[0] ? (acc_reg + a_sh_reg) : acc_reg;
    mul_flags = {(|acc_step[2*WIDTH-1:WIDTH]), 1'b0, acc_step[WIDTH-1],
                 (acc_step[WIDTH-1:0] == '0)};
  end

  // ---------------- datapath / output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      acc_reg       <= '0;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      // Clearing first lets a same-cycle load below win, keeping out_valid high
      // across a back-to-back pop/accept.
      if (pop) out_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              a_sh_reg <= {{WIDTH{1'b0}}, a};
              b_sh_reg <= b;
              acc_reg  <= '0;
              cnt_reg  <= '0;
            end else begin
              result_reg    <= alu_res;
              flags_reg     <= alu_flags;
              out_valid_reg <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_reg  <= acc_step;
          a_sh_reg <= a_sh_reg << 1;
          b_sh_reg <= b_sh_reg >> 1;
          cnt_reg  <= cnt_reg + 1'b1;
          if (mul_done) begin
            result_reg    <= acc_step[WIDTH-1:0];
            flags_reg     <= mul_flags;
            out_valid_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=8): directed scenarios followed by randomized
// traffic, checked every cycle against a transaction-level reference model.

module tb_alu_pipe;

  localparam int W   = 8;
  localparam int SHW = $clog2(W);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: output register contents plus how many MUL edges remain.
  bit           m_valid = 0;
  logic [W-1:0] m_res   = '0;
  logic [3:0]   m_flg   = '0;
  int           m_busy  = 0;
  logic [W+3:0] m_pend  = '0;

  // Reference ALU from plain integer arithmetic: returns {carry,ovf,neg,zero,result}.
  function automatic logic [W+3:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] o);
    longint m  = longint'(1) << W;
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint sx = (ux >= m / 2) ? ux - m : ux;
    longint sy = (uy >= m / 2) ? uy - m : uy;
    longint sh = uy % (longint'(1) << SHW);
    longint full = 0;
    longint s = 0;
    longint r;
    bit c = 0;
    bit v = 0;
    logic [W-1:0] rr;
    case (o)
      3'd0: begin full = ux + uy; c = (full >= m); s = sx + sy; v = (s > m/2 - 1) || (s < -(m/2)); end
      3'd1: begin full = ux - uy; c = (ux < uy);   s = sx - sy; v = (s > m/2 - 1) || (s < -(m/2)); end
      3'd2: full = ux & uy;
      3'd3: full = ux | uy;
      3'd4: full = ux ^ uy;
      3'd5: full = ux << sh;
      3'd6: full = ux >> sh;
      default: begin full = ux * uy; c = (full >= m); end
    endcase
    r = ((full % m) + m) % m;
`ifdef ALU_SAT_EN
    if (v) r = (s > 0) ? (m/2 - 1) : (m/2);
`endif
    rr = r[W-1:0];
    return {c, v, (r >= m/2), (r == 0), rr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance model and DUT, check outputs.
  task automatic cycle(input bit r, input bit iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2:0] iop, input bit ordy);
    bit exp_ir;
    bit acc;
    bit pp;
    rst = r; in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
    #1;
    exp_ir = !r && (m_busy == 0) && (!m_valid || ordy);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    acc = iv && exp_ir;
    pp  = m_valid && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 0; m_res = '0; m_flg = '0; m_busy = 0;
    end else begin
      if (pp) m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin m_valid = 1; {m_flg, m_res} = m_pend; end
      end else if (acc) begin
        if (iop == 3'd7) begin
          m_busy = W;
          m_pend = ref_alu(ia, ib, iop);
        end else begin
          m_valid = 1;
          {m_flg, m_res} = ref_alu(ia, ib, iop);
        end
      end
    end
    if (acc) $display("accept op=%0d a=0x%02h b=0x%02h", iop, ia, ib);
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid || r) begin
      chk("result", 32'(result), 32'(m_res));
      chk("flags", 32'(flags), 32'(m_flg));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;

    // Pin the reference model on hand-computed values.
    chk("pin_add_5_3",   32'(ref_alu(8'd5,   8'd3,  3'd0)), 32'h008);
    chk("pin_sub_9_2",   32'(ref_alu(8'd9,   8'd2,  3'd1)), 32'h007);
    chk("pin_sub_2_9",   32'(ref_alu(8'd2,   8'd9,  3'd1)), 32'hAF9);
`ifdef ALU_SAT_EN
    chk("pin_add_7f_1",  32'(ref_alu(8'h7F,  8'h01, 3'd0)), 32'h47F);
`else
    chk("pin_add_7f_1",  32'(ref_alu(8'h7F,  8'h01, 3'd0)), 32'h680);
`endif
    chk("pin_mul_15_17", 32'(ref_alu(8'd15,  8'd17, 3'd7)), 32'h2FF);
    chk("pin_mul_16_16", 32'(ref_alu(8'd16,  8'd16, 3'd7)), 32'h900);
    chk("pin_xor",       32'(ref_alu(8'hF0,  8'hFF, 3'd4)), 32'h00F);
    chk("pin_shl",       32'(ref_alu(8'h81,  8'h0B, 3'd5)), 32'h008);

    // Reset state.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);

    // Single-cycle ops, one per cycle.
    cycle(0, 1, 8'd5, 8'd3, 3'd0, 1);
    chk("add53_result", 32'(result), 32'd8);
    chk("add53_flags", 32'(flags), 32'd0);
    cycle(0, 1, 8'd9, 8'd2, 3'd1, 1);
    chk("sub92_result", 32'(result), 32'd7);
    cycle(0, 1, 8'd2, 8'd9, 3'd1, 1);
    chk("sub29_result", 32'(result), 32'hF9);
    chk("sub29_flags", 32'(flags), 32'b1010);
    cycle(0, 1, 8'h7F, 8'h01, 3'd0, 1);

    // MUL 15*17: out_valid exactly 9 edges after accept.
    cycle(0, 1, 8'd15, 8'd17, 3'd7, 1);
    for (int i = 0; i < W; i++) cycle(0, 0, 0, 0, 0, 1);
    chk("mul_15_17_result", 32'(result), 32'hFF);
    cycle(0, 1, 8'd16, 8'd16, 3'd7, 1);
    for (int i = 0; i < W; i++) cycle(0, 0, 0, 0, 0, 1);
    chk("mul_16_16_flags", 32'(flags), 32'b1001);

    // Backpressure: ADD 1,1 held for 5 cycles, then pop + XOR in one cycle.
    cycle(0, 1, 8'd1, 8'd1, 3'd0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 8'hF0, 8'hFF, 3'd4, 0);
      chk("held_result", 32'(result), 32'd2);
    end
    cycle(0, 1, 8'hF0, 8'hFF, 3'd4, 1);
    chk("xor_result", 32'(result), 32'h0F);
    chk("xor_valid", 32'(out_valid), 32'd1);

    // Reset on the 4th MUL cycle.
    cycle(0, 1, 8'd3, 8'd5, 3'd7, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    cycle(0, 1, 8'd1, 8'd2, 3'd0, 1);
    chk("add12_result", 32'(result), 32'd3);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7), pick(), pick(),
            3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
